// File: rtl/led_pwm_slave_if.sv
// Byte register bus shared by the LED controller and its sibling register slaves.
interface led_pwm_slave_if;
    logic [13:0] adr;
    logic        we;
    logic [7:0]  dat_w;
    logic [7:0]  dat_r;

    modport master (output adr, output we, output dat_w, input dat_r);
    modport slave  (input adr, input we, input dat_w, output dat_r);
endinterface

// File: rtl/led_pwm_slave.sv
// Bus-mapped LED controller: per-LED source select between direct bit,
// external signals, PWM dimmer and blink generator, polarity applied at the pin.
//
// Blink FSM states (one per LED):
//   state  | meaning
//   B_IDLE | SEL_i is not BLINK; output 0
//   B_ON   | on phase, bcnt counts ticks against ON_i; output 1 unless ON_i==0
//   B_OFF  | off phase, bcnt counts ticks against OFF_i; output 0 (1 if OFF_i==0 and ON_i>0)
module led_pwm_slave #(
    parameter int N       = 4,
    parameter int MUX_N   = 1,
    parameter int ADDR    = 0,
    parameter int ACT_H   = 0,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    led_pwm_slave_if.slave     bus,
    output logic [N-1:0]       leds_wire,
    input  logic [N*MUX_N-1:0] leds_external_signal
);

    localparam logic [4:0] BLK       = 5'(ADDR);
    localparam logic [7:0] SEL_PWM   = 8'(MUX_N + 1);
    localparam logic [7:0] SEL_BLINK = 8'(MUX_N + 2);

    typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} blink_state_e;

    logic               blk_sel, wr_en, rd_en;
    logic [8:0]         offset;
    logic [N-1:0]       direct_r;
    logic [7:0]         presc_l, presc_h;
    logic [7:0]         sel_r    [N];
    logic [PWM_W-1:0]   duty_r   [N];
    logic [PWM_W-1:0]   shadow_r [N];
    logic [7:0]         on_r     [N];
    logic [7:0]         off_r    [N];
    logic [7:0]         rd_data, dat_r_q;
    logic [PWM_W-1:0]   pcnt;
    logic [PRESC_W-1:0] pres_cnt;
    logic               tick;
    blink_state_e       b_state     [N];
    blink_state_e       b_state_nxt [N];
    logic [7:0]         bcnt        [N];
    logic [7:0]         bcnt_nxt    [N];
    logic [N-1:0]       pwm_out, blink_out, led_l;

    assign offset  = bus.adr[8:0];
    assign blk_sel = (bus.adr[13:9] == BLK);
    assign wr_en   = blk_sel && bus.we;
    assign rd_en   = blk_sel && !bus.we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direct_r <= '0;
            presc_l  <= '0;
            presc_h  <= '0;
            for (int i = 0; i < N; i++) begin
                sel_r[i]  <= '0;
                duty_r[i] <= '0;
                on_r[i]   <= '0;
                off_r[i]  <= '0;
            end
        end else if (wr_en) begin
            if (offset == 9'h000) direct_r <= bus.dat_w[N-1:0];
            if (offset == 9'h001) presc_l  <= bus.dat_w;
            if (offset == 9'h002) presc_h  <= bus.dat_w;
            for (int i = 0; i < N; i++) begin
                if (offset == 9'(16 + 4*i)) sel_r[i]  <= bus.dat_w;
                if (offset == 9'(17 + 4*i)) duty_r[i] <= PWM_W'(bus.dat_w);
                if (offset == 9'(18 + 4*i)) on_r[i]   <= bus.dat_w;
                if (offset == 9'(19 + 4*i)) off_r[i]  <= bus.dat_w;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (offset == 9'h000) rd_data = 8'(direct_r);
        if (offset == 9'h001) rd_data = presc_l;
        if (offset == 9'h002) rd_data = presc_h;
        for (int i = 0; i < N; i++) begin
            if (offset == 9'(16 + 4*i)) rd_data = sel_r[i];
            if (offset == 9'(17 + 4*i)) rd_data = 8'(duty_r[i]);
            if (offset == 9'(18 + 4*i)) rd_data = on_r[i];
            if (offset == 9'(19 + 4*i)) rd_data = off_r[i];
        end
    end

    // dat_r holds through writes and foreign-block cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        dat_r_q <= 8'h00;
        else if (rd_en) dat_r_q <= rd_data;
    end

    assign bus.dat_r = dat_r_q;

    // Shadow duty reloads only at the period boundary so a mid-period write
    // never distorts the running period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            for (int i = 0; i < N; i++) shadow_r[i] <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            if (pcnt == '1) begin
                for (int i = 0; i < N; i++) shadow_r[i] <= duty_r[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) pwm_out[i] = (pcnt < shadow_r[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pres_cnt <= '0;
        else if (pres_cnt == '0) pres_cnt <= PRESC_W'({presc_h, presc_l});
        else                     pres_cnt <= pres_cnt - 1'b1;
    end

    assign tick = (pres_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                b_state[i] <= B_IDLE;
                bcnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                b_state[i] <= b_state_nxt[i];
                bcnt[i]    <= bcnt_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            b_state_nxt[i] = b_state[i];
            bcnt_nxt[i]    = bcnt[i];
            blink_out[i]   = 1'b0;
            if (sel_r[i] != SEL_BLINK) begin
                b_state_nxt[i] = B_IDLE;
                bcnt_nxt[i]    = '0;
            end else begin
                case (b_state[i])
                    B_IDLE: begin
                        b_state_nxt[i] = B_ON;
                        bcnt_nxt[i]    = '0;
                    end
                    B_ON: begin
                        if (tick) begin
                            if (({1'b0, bcnt[i]} + 9'd1) >= {1'b0, on_r[i]}) begin
                                b_state_nxt[i] = B_OFF;
                                bcnt_nxt[i]    = '0;
                            end else begin
                                bcnt_nxt[i] = bcnt[i] + 8'd1;
                            end
                        end
                    end
                    B_OFF: begin
                        if (tick) begin
                            if (({1'b0, bcnt[i]} + 9'd1) >= {1'b0, off_r[i]}) begin
                                b_state_nxt[i] = B_ON;
                                bcnt_nxt[i]    = '0;
                            end else begin
                                bcnt_nxt[i] = bcnt[i] + 8'd1;
                            end
                        end
                    end
                    default: begin
                        b_state_nxt[i] = B_IDLE;
                        bcnt_nxt[i]    = '0;
                    end
                endcase
            end
            // Zero-length phases are masked at the output rather than skipped
            blink_out[i] = (on_r[i] != 8'd0) &&
                           ((b_state[i] == B_ON) ||
                            ((b_state[i] == B_OFF) && (off_r[i] == 8'd0)));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            led_l[i] = 1'b0;
            if (sel_r[i] == 8'd0) led_l[i] = direct_r[i];
            for (int j = 0; j < MUX_N; j++) begin
                if (sel_r[i] == 8'(j + 1)) led_l[i] = leds_external_signal[i*MUX_N + j];
            end
            if (sel_r[i] == SEL_PWM)   led_l[i] = pwm_out[i];
            if (sel_r[i] == SEL_BLINK) led_l[i] = blink_out[i];
        end
    end

    assign leds_wire = (ACT_H != 0) ? led_l : ~led_l;

endmodule

// File: tb/tb_led_pwm_slave.sv
// Scoreboard bench for led_pwm_slave: register access, source muxing, PWM, blink, async reset.
module tb_led_pwm_slave;
    localparam int N     = 4;
    localparam int MUX_N = 1;
    localparam int ADDR  = 3;
    localparam logic [4:0] BLK       = 5'(ADDR);
    localparam logic [4:0] OTHER_BLK = 5'(ADDR + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       leds_wire;
    logic [N*MUX_N-1:0] ext = '0;
    int                 n_chk = 0;
    int                 n_err = 0;
    logic [7:0]         exp_q [$];
    int unsigned        cyc;

    led_pwm_slave_if bus ();

    led_pwm_slave #(
        .N(N), .MUX_N(MUX_N), .ADDR(ADDR), .ACT_H(0), .PWM_W(8), .PRESC_W(16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .leds_wire            (leds_wire),
        .leds_external_signal (ext)
    );

    always #5 clk = ~clk;

    // reference for the free-running PWM counter: cycles since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp_v);
        end
    endtask

    task automatic bus_idle();
        bus.adr   = {OTHER_BLK, 9'h000};
        bus.we    = 1'b0;
        bus.dat_w = 8'h00;
    endtask

    task automatic wr(input logic [4:0] blk, input logic [8:0] off, input logic [7:0] d);
        @(negedge clk);
        bus.adr   = {blk, off};
        bus.we    = 1'b1;
        bus.dat_w = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input logic [8:0] off, input logic [7:0] exp_v, input string tag);
        logic [7:0] e;
        @(negedge clk);
        bus.adr = {BLK, off};
        bus.we  = 1'b0;
        exp_q.push_back(exp_v);
        @(negedge clk);
        bus_idle();
        e = exp_q.pop_front();
        chk(tag, 32'(bus.dat_r), 32'(e));
    endtask

    task automatic count_on(input int idx, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (leds_wire[idx] == 1'b0) cnt++;
        end
    endtask

    task automatic wait_rise(input int idx, input int budget, output int ok);
        logic prev;
        ok   = 0;
        prev = ~leds_wire[idx];
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!prev && !leds_wire[idx]) begin
                ok = 1;
                break;
            end
            prev = ~leds_wire[idx];
        end
    endtask

    task automatic run_len(input int idx, input logic lvl, output int len);
        len = 0;
        while ((~leds_wire[idx]) == lvl && len < 200) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int ok;
        int len;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_leds", 32'(leds_wire), 32'hF);
        chk("rst_dat_r", 32'(bus.dat_r), 0);
        rst = 1'b0;

        rd(9'h010, 8'h00, "rd_sel0_rst");
        wr(BLK, 9'h000, 8'h05);
        chk("direct_05", 32'(leds_wire), 32'b1010);
        wr(OTHER_BLK, 9'h000, 8'h0F);
        chk("other_blk_wr", 32'(leds_wire), 32'b1010);
        rd(9'h000, 8'h05, "rd_direct");
        wr(BLK, 9'h001, 8'h03);
        chk("hold_on_wr", 32'(bus.dat_r), 32'h05);
        wr(BLK, 9'h024, 8'h33);
        rd(9'h024, 8'h00, "rd_sel5_unmapped");
        rd(9'h1FF, 8'h00, "rd_unmapped");
        rd(9'h001, 8'h03, "rd_presc_l");

        // external source on LED1, active-low pin
        wr(BLK, 9'h014, 8'h01);
        chk("ext_lo0", 32'(leds_wire[1]), 1);
        ext[1] = 1'b1;
        #1 chk("ext_hi", 32'(leds_wire[1]), 0);
        ext[1] = 1'b0;
        #1 chk("ext_lo", 32'(leds_wire[1]), 1);
        wr(BLK, 9'h014, 8'h7F);
        ext[1] = 1'b1;
        #1 chk("sel_off", 32'(leds_wire[1]), 1);
        ext[1] = 1'b0;

        // PWM on LED0, DUTY written when pcnt==100
        wr(BLK, 9'h010, 8'h02);
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            if (cyc[7:0] == 8'd99) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("pwm_align", 32'(ok), 1);
        wr(BLK, 9'h011, 8'd64);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            if (leds_wire[0] == 1'b0) cnt++;
            if (cyc[7:0] == 8'd255) break;
            @(negedge clk);
        end
        chk("pwm_cur_period", 32'(cnt), 0);
        count_on(0, 256, cnt);
        chk("pwm_duty64", 32'(cnt), 64);
        wr(BLK, 9'h011, 8'd0);
        repeat (300) @(negedge clk);
        count_on(0, 256, cnt);
        chk("pwm_duty0", 32'(cnt), 0);
        wr(BLK, 9'h011, 8'd255);
        repeat (300) @(negedge clk);
        count_on(0, 256, cnt);
        chk("pwm_duty255", 32'(cnt), 255);
        rd(9'h011, 8'hFF, "rd_duty0");

        // blink on LED2: tick every 4 cycles, 2 on-ticks, 3 off-ticks
        wr(BLK, 9'h002, 8'h00);
        wr(BLK, 9'h01A, 8'd2);
        wr(BLK, 9'h01B, 8'd3);
        wr(BLK, 9'h018, 8'h03);
        repeat (30) @(negedge clk);
        wait_rise(2, 100, ok);
        chk("blink_rise", 32'(ok), 1);
        run_len(2, 1'b1, len);
        chk("blink_on1", 32'(len), 8);
        run_len(2, 1'b0, len);
        chk("blink_off1", 32'(len), 12);
        run_len(2, 1'b1, len);
        chk("blink_on2", 32'(len), 8);
        run_len(2, 1'b0, len);
        chk("blink_off2", 32'(len), 12);

        wr(BLK, 9'h01A, 8'd0);
        count_on(2, 48, cnt);
        chk("blink_on0", 32'(cnt), 0);
        wr(BLK, 9'h01B, 8'd0);
        wr(BLK, 9'h01A, 8'd1);
        count_on(2, 48, cnt);
        chk("blink_off0", 32'(cnt), 48);

        // async reset during an on phase
        wr(BLK, 9'h01B, 8'd3);
        wr(BLK, 9'h01A, 8'd2);
        wait_rise(2, 100, ok);
        chk("blink_rise_rst", 32'(ok), 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_leds", 32'(leds_wire), 32'hF);
        chk("rst_async_dat_r", 32'(bus.dat_r), 0);
        @(negedge clk);
        rst = 1'b0;
        rd(9'h018, 8'h00, "rd_sel2_after_rst");
        rd(9'h01A, 8'h00, "rd_on2_after_rst");
        rd(9'h000, 8'h00, "rd_direct_after_rst");
        count_on(2, 40, cnt);
        chk("idle_after_rst", 32'(cnt), 0);
        chk("leds_after_rst", 32'(leds_wire), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
